// File: rtl/scalar_wb_queue_pkg.sv
// scalar_wb_pkg: default widths and the entry layout shared by the scalar
// writeback queue, its interface and its users.
package scalar_wb_pkg;

    localparam int DATA_WIDTH   = 48;
    localparam int ADDRESSWIDTH = 4;
    localparam int DEPTH        = 8;

    // One pending register-file write: destination register and result.
    typedef struct packed {
        logic [ADDRESSWIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0]   data;
    } wb_entry_t;

    // Occupancy counter width; it must be able to hold DEPTH itself.
    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // Number of results accepted in one cycle (0..2).
    function automatic logic [1:0] push_count(input logic push_a, input logic push_b);
        return {1'b0, push_a} + {1'b0, push_b};
    endfunction

endpackage

// File: rtl/scalar_wb_queue_if.sv
// scalar_wb_queue_if: result inputs from execute/memory, the register-file
// write port and queue occupancy. Build option WB_BYPASS_EN adds the two
// forwarding lookup ports used by decode.
interface scalar_wb_queue_if #(
    parameter int DATA_WIDTH   = scalar_wb_pkg::DATA_WIDTH,
    parameter int ADDRESSWIDTH = scalar_wb_pkg::ADDRESSWIDTH,
    parameter int DEPTH        = scalar_wb_pkg::DEPTH
);

    logic                      alu_valid;
    logic [ADDRESSWIDTH-1:0]   alu_addr;
    logic [DATA_WIDTH-1:0]     alu_data;
    logic                      mem_valid;
    logic [ADDRESSWIDTH-1:0]   mem_addr;
    logic [DATA_WIDTH-1:0]     mem_data;
    logic                      in_ready;
    logic                      wb_we;
    logic [ADDRESSWIDTH-1:0]   wb_wa;
    logic [DATA_WIDTH-1:0]     wb_wd;
    logic [$clog2(DEPTH):0]    count;
`ifdef WB_BYPASS_EN
    logic [ADDRESSWIDTH-1:0]   byp_ra1;
    logic [ADDRESSWIDTH-1:0]   byp_ra2;
    logic                      byp_hit1;
    logic                      byp_hit2;
    logic [DATA_WIDTH-1:0]     byp_data1;
    logic [DATA_WIDTH-1:0]     byp_data2;
`endif

    // Producer / consumer side (pipeline stages and register file).
    modport master (
        output alu_valid, alu_addr, alu_data, mem_valid, mem_addr, mem_data,
`ifdef WB_BYPASS_EN
        output byp_ra1, byp_ra2,
        input  byp_hit1, byp_hit2, byp_data1, byp_data2,
`endif
        input  in_ready, wb_we, wb_wa, wb_wd, count
    );

    // Queue side.
    modport slave (
        input  alu_valid, alu_addr, alu_data, mem_valid, mem_addr, mem_data,
`ifdef WB_BYPASS_EN
        input  byp_ra1, byp_ra2,
        output byp_hit1, byp_hit2, byp_data1, byp_data2,
`endif
        output in_ready, wb_we, wb_wa, wb_wd, count
    );

endinterface

// File: rtl/scalar_wb_queue_fifo.sv
// scalar_wb_fifo: storage for the writeback queue. Two write ports (port A is
// the older result when both write), one read port at the head, wrapping
// pointers and an occupancy count. Full/empty are judged from the count.
// With WB_BYPASS_EN the raw slots and head pointer are exported for lookup.
module scalar_wb_fifo #(
    parameter int DATA_WIDTH   = scalar_wb_pkg::DATA_WIDTH,
    parameter int ADDRESSWIDTH = scalar_wb_pkg::ADDRESSWIDTH,
    parameter int DEPTH        = scalar_wb_pkg::DEPTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push_a,
    input  logic [ADDRESSWIDTH-1:0]   a_addr,
    input  logic [DATA_WIDTH-1:0]     a_data,
    input  logic                      push_b,
    input  logic [ADDRESSWIDTH-1:0]   b_addr,
    input  logic [DATA_WIDTH-1:0]     b_data,
    input  logic                      pop,
    output logic [ADDRESSWIDTH-1:0]   head_addr,
    output logic [DATA_WIDTH-1:0]     head_data,
`ifdef WB_BYPASS_EN
    output logic [$clog2(DEPTH)-1:0]  head_ptr,
    output logic [ADDRESSWIDTH-1:0]   ent_addr [DEPTH],
    output logic [DATA_WIDTH-1:0]     ent_data [DEPTH],
`endif
    output logic [$clog2(DEPTH):0]    count
);
    import scalar_wb_pkg::*;

    localparam int PW = $clog2(DEPTH);
    localparam int CW = count_width(DEPTH);

    logic [ADDRESSWIDTH-1:0] addr_r [DEPTH];
    logic [DATA_WIDTH-1:0]   data_r [DEPTH];
    logic [PW-1:0]           head_r;
    logic [PW-1:0]           tail_r;
    logic [CW-1:0]           count_r;
    logic [PW-1:0]           tail_b_s;
    logic [1:0]              push_cnt_s;

    // Port B lands right behind port A when both write, otherwise at the tail.
    always_comb begin
        push_cnt_s = push_count(push_a, push_b);
        tail_b_s   = tail_r + PW'(push_a);
    end

    // Slot storage; not reset because occupancy alone decides what is live.
    always_ff @(posedge clk) begin
        if (push_a) begin
            addr_r[tail_r] <= a_addr;
            data_r[tail_r] <= a_data;
        end
        if (push_b) begin
            addr_r[tail_b_s] <= b_addr;
            data_r[tail_b_s] <= b_data;
        end
    end

    // Pointers and occupancy; pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_r  <= {PW{1'b0}};
            tail_r  <= {PW{1'b0}};
            count_r <= {CW{1'b0}};
        end else begin
            head_r  <= head_r + PW'(pop);
            tail_r  <= tail_r + PW'(push_cnt_s);
            count_r <= count_r + CW'(push_cnt_s) - CW'(pop);
        end
    end

    assign head_addr = addr_r[head_r];
    assign head_data = data_r[head_r];
    assign count     = count_r;

`ifdef WB_BYPASS_EN
    assign head_ptr = head_r;

    // Expose every slot to the forwarding search in the top level.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ent_addr[i] = addr_r[i];
            ent_data[i] = data_r[i];
        end
    end
`endif

endmodule

// File: rtl/scalar_wb_queue.sv
// scalar_wb_queue: in-order writeback queue that owns the single write port
// (we3/wa3/wd3) of the scalar register file. Up to two results per cycle are
// accepted (ALU before load), one is retired per cycle, unconditionally.
// Build option: WB_BYPASS_EN adds two combinational forwarding lookups that
// return the youngest queued value for a register.
module scalar_wb_queue #(
    parameter int DATA_WIDTH   = scalar_wb_pkg::DATA_WIDTH,
    parameter int ADDRESSWIDTH = scalar_wb_pkg::ADDRESSWIDTH,
    parameter int DEPTH        = scalar_wb_pkg::DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    scalar_wb_queue_if.slave bus
);
    import scalar_wb_pkg::*;

    localparam int CW = count_width(DEPTH);

    logic [CW-1:0]           count_s;
    logic                    in_ready_s;
    logic                    alu_push_s;
    logic                    mem_push_s;
    logic                    pop_s;
    logic [ADDRESSWIDTH-1:0] head_addr_s;
    logic [DATA_WIDTH-1:0]   head_data_s;
    logic                    wb_we_s;
    logic [ADDRESSWIDTH-1:0] wb_wa_s;
    logic [DATA_WIDTH-1:0]   wb_wd_s;

`ifdef WB_BYPASS_EN
    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0]           head_ptr_s;
    logic [ADDRESSWIDTH-1:0] ent_addr_s [DEPTH];
    logic [DATA_WIDTH-1:0]   ent_data_s [DEPTH];
    logic                    hit1_s;
    logic                    hit2_s;
    logic [DATA_WIDTH-1:0]   data1_s;
    logic [DATA_WIDTH-1:0]   data2_s;
`endif

    // Admission needs room for two results and looks only at registered
    // occupancy, so ready never depends on this cycle's valids or pop.
    always_comb begin
        in_ready_s = (count_s <= CW'(DEPTH - 2));
        alu_push_s = bus.alu_valid & in_ready_s;
        mem_push_s = bus.mem_valid & in_ready_s;
        pop_s      = (count_s != {CW{1'b0}}) & ~rst;
    end

    scalar_wb_fifo #(
        .DATA_WIDTH   (DATA_WIDTH),
        .ADDRESSWIDTH (ADDRESSWIDTH),
        .DEPTH        (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push_a    (alu_push_s),
        .a_addr    (bus.alu_addr),
        .a_data    (bus.alu_data),
        .push_b    (mem_push_s),
        .b_addr    (bus.mem_addr),
        .b_data    (bus.mem_data),
        .pop       (pop_s),
        .head_addr (head_addr_s),
        .head_data (head_data_s),
`ifdef WB_BYPASS_EN
        .head_ptr  (head_ptr_s),
        .ent_addr  (ent_addr_s),
        .ent_data  (ent_data_s),
`endif
        .count     (count_s)
    );

    // Present the head to the register file whenever one exists; a cycle in
    // reset writes nothing, so discarded entries can never reach the file.
    always_comb begin
        if (pop_s) begin
            wb_we_s = 1'b1;
            wb_wa_s = head_addr_s;
            wb_wd_s = head_data_s;
        end else begin
            wb_we_s = 1'b0;
            wb_wa_s = {ADDRESSWIDTH{1'b0}};
            wb_wd_s = {DATA_WIDTH{1'b0}};
        end
    end

    assign bus.in_ready = in_ready_s;
    assign bus.wb_we    = wb_we_s;
    assign bus.wb_wa    = wb_wa_s;
    assign bus.wb_wd    = wb_wd_s;
    assign bus.count    = count_s;

`ifdef WB_BYPASS_EN
    // Walk live slots oldest to youngest so the last match seen is the youngest;
    // the head being retired this cycle still counts as live.
    always_comb begin
        logic [PW-1:0] idx;
        logic          live;
        logic          m1;
        logic          m2;
        idx     = head_ptr_s;
        live    = 1'b0;
        m1      = 1'b0;
        m2      = 1'b0;
        hit1_s  = 1'b0;
        hit2_s  = 1'b0;
        data1_s = {DATA_WIDTH{1'b0}};
        data2_s = {DATA_WIDTH{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            idx     = head_ptr_s + PW'(i);
            live    = (CW'(i) < count_s);
            m1      = live && (ent_addr_s[idx] == bus.byp_ra1);
            m2      = live && (ent_addr_s[idx] == bus.byp_ra2);
            hit1_s  = hit1_s | m1;
            hit2_s  = hit2_s | m2;
            data1_s = m1 ? ent_data_s[idx] : data1_s;
            data2_s = m2 ? ent_data_s[idx] : data2_s;
        end
    end

    assign bus.byp_hit1  = hit1_s;
    assign bus.byp_hit2  = hit2_s;
    assign bus.byp_data1 = data1_s;
    assign bus.byp_data2 = data2_s;
`endif

endmodule

// File: tb/tb_scalar_wb_queue.sv
// tb_scalar_wb_queue: directed self-checking bench for scalar_wb_queue.
// Expected values are hand-computed constants plus a small occupancy model;
// a register-file model and retire log observe the write port.
module tb_scalar_wb_queue;
    import scalar_wb_pkg::*;

    localparam int DW  = 48;
    localparam int AW  = 4;
    localparam int DEP = 8;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    scalar_wb_queue_if #(.DATA_WIDTH(DW), .ADDRESSWIDTH(AW), .DEPTH(DEP)) bus ();

    scalar_wb_queue #(.DATA_WIDTH(DW), .ADDRESSWIDTH(AW), .DEPTH(DEP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    logic [DW-1:0] rf [16];
    wb_entry_t     retired [$];

    // Register-file model: record each write mid-cycle, before the edge commits it.
    always @(negedge clk) begin
        if (bus.wb_we === 1'b1) begin
            rf[bus.wb_wa] <= bus.wb_wd;
            retired.push_back({bus.wb_wa, bus.wb_wd});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total = total + 1;
        assert (obs === exp) else begin
            bad = bad + 1;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        wb_entry_t     e;
        wb_entry_t     exp_q [$];
        wb_entry_t     got;
        int            mark;
        int            k;
        int            exp_cnt;
        logic          rdy;

        rst           = 1'b1;
        bus.alu_valid = 1'b0;
        bus.alu_addr  = 4'd0;
        bus.alu_data  = 48'h0;
        bus.mem_valid = 1'b0;
        bus.mem_addr  = 4'd0;
        bus.mem_data  = 48'h0;
`ifdef WB_BYPASS_EN
        bus.byp_ra1   = 4'd0;
        bus.byp_ra2   = 4'd0;
`endif

        // ---- reset state ----
        tick();
        check("rst_we_in_reset", bus.wb_we, 1'b0);
        tick();
        rst = 1'b0;
        #1;
        check("rst_we", bus.wb_we, 1'b0);
        check("rst_wa", bus.wb_wa, 4'd0);
        check("rst_wd", bus.wb_wd, 48'h0);
        check("rst_ready", bus.in_ready, 1'b1);
        check("rst_count", bus.count, 4'd0);

        // ---- 1: idle for 10 cycles ----
        for (int c = 0; c < 10; c++) begin
            tick();
            check("idle", {bus.wb_we, bus.in_ready, bus.count}, {1'b0, 1'b1, 4'd0});
        end

        // ---- 2: single ALU push r3=0x1234 ----
        bus.alu_valid = 1'b1;
        bus.alu_addr  = 4'd3;
        bus.alu_data  = 48'h1234;
        tick();
        bus.alu_valid = 1'b0;
        check("t2_we", bus.wb_we, 1'b1);
        check("t2_wa", bus.wb_wa, 4'd3);
        check("t2_wd", bus.wb_wd, 48'h1234);
        check("t2_count1", bus.count, 4'd1);
        tick();
        check("t2_count0", bus.count, 4'd0);
        check("t2_we_off", bus.wb_we, 1'b0);
        check("t2_rf3", rf[3], 48'h1234);

        // ---- single load push lands at the tail alone ----
        bus.mem_valid = 1'b1;
        bus.mem_addr  = 4'd6;
        bus.mem_data  = 48'hC;
        tick();
        bus.mem_valid = 1'b0;
        check("mem_only_wa", bus.wb_wa, 4'd6);
        check("mem_only_wd", bus.wb_wd, 48'hC);
        check("mem_only_count", bus.count, 4'd1);
        tick();

        // ---- 3: same-cycle ALU r5=0xA and load r5=0xB ----
        mark = retired.size();
        bus.alu_valid = 1'b1;
        bus.alu_addr  = 4'd5;
        bus.alu_data  = 48'hA;
        bus.mem_valid = 1'b1;
        bus.mem_addr  = 4'd5;
        bus.mem_data  = 48'hB;
        tick();
        bus.alu_valid = 1'b0;
        bus.mem_valid = 1'b0;
        check("t3_first_wa", bus.wb_wa, 4'd5);
        check("t3_first_wd", bus.wb_wd, 48'hA);
        check("t3_count2", bus.count, 4'd2);
        tick();
        check("t3_second_wd", bus.wb_wd, 48'hB);
        check("t3_count1", bus.count, 4'd1);
        tick();
        check("t3_count0", bus.count, 4'd0);
        check("t3_rf5", rf[5], 48'hB);
        check("t3_nretired", retired.size() - mark, 2);

        // ---- 4: both valid every cycle from empty ----
        mark = retired.size();
        k = 0;
        exp_cnt = 0;
        for (int c = 0; c < 14; c++) begin
            bus.alu_valid = 1'b1;
            bus.alu_addr  = AW'(k);
            bus.alu_data  = 48'h100 + DW'(2 * k);
            bus.mem_valid = 1'b1;
            bus.mem_addr  = AW'(k + 7);
            bus.mem_data  = 48'h200 + DW'(2 * k + 1);
            check("t4_count", bus.count, exp_cnt);
            rdy = (exp_cnt <= DEP - 2);
            check("t4_ready", bus.in_ready, rdy);
            if (rdy) begin
                e.addr = AW'(k);
                e.data = 48'h100 + DW'(2 * k);
                exp_q.push_back(e);
                e.addr = AW'(k + 7);
                e.data = 48'h200 + DW'(2 * k + 1);
                exp_q.push_back(e);
                k = k + 1;
            end
            exp_cnt = exp_cnt + (rdy ? 2 : 0) - ((exp_cnt > 0) ? 1 : 0);
            tick();
        end
        bus.alu_valid = 1'b0;
        bus.mem_valid = 1'b0;
        check("t4_count_full", bus.count, exp_cnt);
        for (int c = 0; c < 20 && bus.count != 4'd0; c++) begin
            tick();
        end
        check("t4_drained", bus.count, 4'd0);
        check("t4_nretired", retired.size() - mark, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            got = (mark + i < retired.size()) ? retired[mark + i] : '{addr: 4'd0, data: 48'h0};
            check($sformatf("t4_order[%0d]", i), got, exp_q[i]);
        end

        // ---- 5: reset with 5 entries queued ----
        mark = retired.size();
        for (int c = 0; c < 4; c++) begin
            bus.alu_valid = 1'b1;
            bus.alu_addr  = AW'(8 + c);
            bus.alu_data  = 48'hDEAD00 + DW'(c);
            bus.mem_valid = 1'b1;
            bus.mem_addr  = AW'(12 + c);
            bus.mem_data  = 48'hBEEF00 + DW'(c);
            tick();
        end
        bus.alu_valid = 1'b0;
        bus.mem_valid = 1'b0;
        check("t5_count5", bus.count, 4'd5);
        rst = 1'b1;
        #1;
        check("t5_we_in_reset", bus.wb_we, 1'b0);
        tick();
        rst = 1'b0;
        #1;
        check("t5_we_after", bus.wb_we, 1'b0);
        check("t5_count_after", bus.count, 4'd0);
        check("t5_ready_after", bus.in_ready, 1'b1);
        for (int c = 0; c < 6; c++) begin
            tick();
        end
        check("t5_no_stale", retired.size() - mark, 3);
        check("t5_rf11_untouched", (rf[11] === 48'hDEAD03) ? 1'b1 : 1'b0, 1'b0);

`ifdef WB_BYPASS_EN
        // ---- 6: forwarding lookup, queue holds r2=1, r7=2, r2=3 ----
        bus.alu_valid = 1'b1;
        bus.alu_addr  = 4'd1;
        bus.alu_data  = 48'h77;
        bus.mem_valid = 1'b1;
        bus.mem_addr  = 4'd2;
        bus.mem_data  = 48'h1;
        tick();
        bus.alu_addr  = 4'd7;
        bus.alu_data  = 48'h2;
        bus.mem_addr  = 4'd2;
        bus.mem_data  = 48'h3;
        tick();
        // this cycle's push of r9 must not be visible to the lookup
        bus.alu_valid = 1'b1;
        bus.alu_addr  = 4'd9;
        bus.alu_data  = 48'h99;
        bus.mem_valid = 1'b0;
        bus.byp_ra1   = 4'd2;
        bus.byp_ra2   = 4'd9;
        #1;
        check("t6_count3", bus.count, 4'd3);
        check("t6_hit1", bus.byp_hit1, 1'b1);
        check("t6_data1", bus.byp_data1, 48'h3);
        check("t6_hit2", bus.byp_hit2, 1'b0);
        check("t6_data2", bus.byp_data2, 48'h0);
        bus.alu_valid = 1'b0;
        bus.byp_ra1   = 4'd7;
        bus.byp_ra2   = 4'd1;
        #1;
        check("t6_hit_r7", {bus.byp_hit1, bus.byp_data1}, {1'b1, 48'h2});
        check("t6_miss_popped_r1", {bus.byp_hit2, bus.byp_data2}, {1'b0, 48'h0});
        for (int c = 0; c < 12 && bus.count != 4'd0; c++) begin
            tick();
        end
        check("t6_drained", bus.count, 4'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
